// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the iterative AES-128 inverse-cipher scheduler.
package aes_dec_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned AES_BLK = 128;
    localparam int unsigned RM_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEYWAIT = 2'd1,
        ST_ROUND   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [RM_W-1:0] RM_INIT  = 2'd0;
    localparam logic [RM_W-1:0] RM_MID   = 2'd1;
    localparam logic [RM_W-1:0] RM_FINAL = 2'd2;

endpackage

// File: rtl/aes_dec_round_sched.sv
// Iterative AES-128 decrypt scheduler: holds the key, runs one shared round unit
// through INIT, NR-1 inverse rounds and FINAL, and hands back the plaintext.
module aes_dec_round_sched
    import aes_dec_pkg::*;
#(
    parameter int unsigned NR      = AES_NR,
    parameter int unsigned KEY_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic [AES_BLK-1:0] key_in,
    output logic [AES_BLK-1:0] key_out,
    output logic               key_drop,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AES_BLK-1:0] cipher_text,
    output logic [AES_BLK-1:0] rnd_state,
    output logic [RM_W-1:0]    rnd_mode,
    output logic [3:0]         rk_idx,
    input  logic [AES_BLK-1:0] rnd_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AES_BLK-1:0] plain_text,
    output logic               busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WAIT_W = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
    localparam logic [CNT_W-1:0]  NR_C      = CNT_W'(NR);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(KEY_LAT - 1);

    state_e               state_q, state_d;
    logic                 key_valid_q, key_valid_d;
    logic [AES_BLK-1:0]   key_q, key_d;
    logic [CNT_W-1:0]     rnd_cnt_q, rnd_cnt_d;
    logic [AES_BLK-1:0]   data_q, data_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 key_drop_q, key_drop_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            rnd_cnt_q   <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            key_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            rnd_cnt_q   <= rnd_cnt_d;
            data_q      <= data_d;
            wait_q      <= wait_d;
            key_drop_q  <= key_drop_d;
        end
    end

    // Next-state and round-unit control
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        key_d       = key_q;
        rnd_cnt_d   = rnd_cnt_q;
        data_d      = data_q;
        wait_d      = wait_q;
        key_drop_d  = 1'b0;
        in_ready    = 1'b0;
        rnd_mode    = RM_INIT;
        rk_idx      = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = key_valid_q & ~key_load;
                // A key load takes priority over a pending block
                if (key_load) begin
                    key_d       = key_in;
                    key_valid_d = 1'b0;
                    wait_d      = WAIT_INIT;
                    state_d     = ST_KEYWAIT;
                end else if (in_valid && key_valid_q) begin
                    data_d    = cipher_text;
                    rnd_cnt_d = '0;
                    state_d   = ST_ROUND;
                end
            end
            ST_KEYWAIT: begin
                key_drop_d = key_load;
                if (wait_q == '0) begin
                    key_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_ROUND: begin
                key_drop_d = key_load;
                rk_idx     = NR_C - rnd_cnt_q;
                if (rnd_cnt_q == '0) begin
                    rnd_mode = RM_INIT;
                end else if (rnd_cnt_q == NR_C) begin
                    rnd_mode = RM_FINAL;
                end else begin
                    rnd_mode = RM_MID;
                end
                data_d    = rnd_out;
                rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
                if (rnd_cnt_q == NR_C) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                key_drop_d = key_load;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign key_out    = key_q;
    assign key_drop   = key_drop_q;
    assign rnd_state  = data_q;
    assign plain_text = data_q;
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

endmodule
